xip_miss_sequencer: RTL and testbench

//  Two-port front end for the XIP flash cache. Serves 32-bit word reads from an

---
 rtl/xip_miss_sequencer.sv | 124 ++++++++++++
 tb/tb_xip_miss_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xip_miss_sequencer.sv
// Two-port read front end for the XIP flash cache: round-robin arbitration,
// cache lookup, and single-line QSPI fill sequencing on a miss.
module xip_miss_sequencer #(
    parameter int unsigned CNT_W      = 16,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             p0_req,
    input  logic [23:0]      p0_addr,
    output logic             p0_ack,
    output logic [31:0]      p0_rdata,
    input  logic             p1_req,
    input  logic [23:0]      p1_addr,
    output logic             p1_ack,
    output logic [31:0]      p1_rdata,
    output logic [23:0]      c_addr,
    input  logic             c_hit,
    input  logic [31:0]      c_do,
    output logic             c_wr,
    output logic [23:0]      fr_addr,
    output logic             fr_rd,
    input  logic             fr_done,
    output logic             busy,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_MISS   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_FILL   = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    logic [2:0]       r_state;
    logic             r_sel;       // 0 = p0, 1 = p1
    logic             r_last;      // last granted port, 1 = p1
    logic             r_first;     // first lookup of the current transaction
    logic [23:0]      r_cur_addr;
    logic [23:0]      r_fr_addr;
    logic [31:0]      r_p0_rdata;
    logic [31:0]      r_p1_rdata;
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_miss_cnt;
    logic             w_grant_p1;
    logic [23:0]      w_grant_addr;

    // Ties go to the port not granted last, unless p0 is given fixed priority.
    always_comb begin
        w_grant_p1 = 1'b0;
        if (p1_req && !p0_req)
            w_grant_p1 = 1'b1;
        else if (p0_req && p1_req && !FIXED_PRIO)
            w_grant_p1 = ~r_last;
        w_grant_addr = w_grant_p1 ? p1_addr : p0_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sel      <= 1'b0;
            r_last     <= 1'b1;
            r_first    <= 1'b0;
            r_cur_addr <= '0;
            r_fr_addr  <= '0;
            r_p0_rdata <= '0;
            r_p1_rdata <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (p0_req || p1_req) begin
                        r_sel      <= w_grant_p1;
                        r_last     <= w_grant_p1;
                        r_cur_addr <= w_grant_addr;
                        r_first    <= 1'b1;
                        r_state    <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (c_hit) begin
                        if (r_sel)
                            r_p1_rdata <= c_do;
                        else
                            r_p0_rdata <= c_do;
                        if (r_first && (r_hit_cnt != '1))
                            r_hit_cnt <= r_hit_cnt + 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        if (r_miss_cnt != '1)
                            r_miss_cnt <= r_miss_cnt + 1'b1;
                        r_fr_addr <= {r_cur_addr[23:4], 4'h0};
                        r_first   <= 1'b0;
                        r_state   <= S_MISS;
                    end
                end
                S_MISS: r_state <= S_WAIT;
                S_WAIT: begin
                    if (fr_done)
                        r_state <= S_FILL;
                end
                // Fill lands one cycle after fr_done: the last nibble arrives on that edge.
                S_FILL:  r_state <= S_LOOKUP;
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign p0_ack   = (r_state == S_RESP) && !r_sel;
    assign p1_ack   = (r_state == S_RESP) &&  r_sel;
    assign p0_rdata = r_p0_rdata;
    assign p1_rdata = r_p1_rdata;
    assign c_addr   = r_cur_addr;
    assign c_wr     = (r_state == S_FILL);
    assign fr_addr  = r_fr_addr;
    assign fr_rd    = (r_state == S_MISS);
    assign busy     = (r_state != S_IDLE);
    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_xip_miss_sequencer.sv
// Directed bench for xip_miss_sequencer: behavioural flash reader and
// direct-mapped cache around one round-robin instance, plus a fixed-priority one.
module tb_xip_miss_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        p0_req = 1'b0, p1_req = 1'b0;
    logic [23:0] p0_addr = '0, p1_addr = '0;
    logic        p0_ack, p1_ack;
    logic [31:0] p0_rdata, p1_rdata;
    logic [23:0] c_addr, fr_addr;
    logic        c_hit, c_wr, fr_rd, busy;
    logic [31:0] c_do;
    logic        fr_done = 1'b0;
    logic [15:0] hit_cnt, miss_cnt;

    logic        f_p0_req = 1'b0, f_p1_req = 1'b0;
    logic [23:0] f_p0_addr = '0, f_p1_addr = '0;
    logic        f_p0_ack, f_p1_ack, f_c_wr, f_fr_rd, f_busy;
    logic [31:0] f_p0_rdata, f_p1_rdata, f_c_do;
    logic [23:0] f_c_addr, f_fr_addr;
    logic [1:0]  f_hit_cnt, f_miss_cnt;

    xip_miss_sequencer #(.CNT_W(16), .FIXED_PRIO(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .c_addr(c_addr), .c_hit(c_hit), .c_do(c_do), .c_wr(c_wr),
        .fr_addr(fr_addr), .fr_rd(fr_rd), .fr_done(fr_done),
        .busy(busy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // Always-hitting cache, never-completing reader: exercises priority and saturation.
    assign f_c_do = {8'hC0, f_c_addr};
    xip_miss_sequencer #(.CNT_W(2), .FIXED_PRIO(1'b1)) u_dut_fixed (
        .clk(clk), .rst_n(rst_n),
        .p0_req(f_p0_req), .p0_addr(f_p0_addr), .p0_ack(f_p0_ack), .p0_rdata(f_p0_rdata),
        .p1_req(f_p1_req), .p1_addr(f_p1_addr), .p1_ack(f_p1_ack), .p1_rdata(f_p1_rdata),
        .c_addr(f_c_addr), .c_hit(1'b1), .c_do(f_c_do), .c_wr(f_c_wr),
        .fr_addr(f_fr_addr), .fr_rd(f_fr_rd), .fr_done(1'b0),
        .busy(f_busy), .hit_cnt(f_hit_cnt), .miss_cnt(f_miss_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] flash_word(input logic [23:0] a);
        return {8'h5A, a[23:2], 2'b00};
    endfunction

    // 64-line x 16 B direct-mapped cache model sharing rst_n.
    logic [63:0] v;
    logic [13:0] ctag [64];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            v <= '0;
        else if (c_wr) begin
            v[c_addr[9:4]]    <= 1'b1;
            ctag[c_addr[9:4]] <= c_addr[23:10];
        end
    end
    always_comb begin
        c_hit = v[c_addr[9:4]] && (ctag[c_addr[9:4]] == c_addr[23:10]);
        c_do  = c_hit ? flash_word(c_addr) : 32'hDEADBEEF;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Flash reader model (fr_done 3 cycles after fr_rd) and event monitor.
    int rd_cnt = 0, n_frrd = 0, done_cyc = -1, wr_cyc = -1;
    int a0_cyc = -1, a1_cyc = -1, n_a0 = 0, n_a1 = 0, nf0 = 0, nf1 = 0;
    logic [23:0] frrd_addr = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_cnt  = 0;
            fr_done = 1'b0;
        end else begin
            fr_done = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) fr_done = 1'b1;
            end
            if (fr_done) done_cyc = cyc;
            if (fr_rd) begin
                n_frrd++;
                frrd_addr = fr_addr;
                rd_cnt    = 3;
            end
        end
        if (c_wr)   wr_cyc = cyc;
        if (p0_ack) begin n_a0++; a0_cyc = cyc; end
        if (p1_ack) begin n_a1++; a1_cyc = cyc; end
        if (f_p0_ack) nf0++;
        if (f_p1_ack) nf1++;
    end

    task automatic do_req(input bit port, input logic [23:0] a, output int req_cyc);
        int base;
        @(posedge clk); #1;
        if (port) begin p1_addr = a; p1_req = 1'b1; end
        else      begin p0_addr = a; p0_req = 1'b1; end
        req_cyc = cyc;
        base = port ? n_a1 : n_a0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if ((port ? n_a1 : n_a0) != base) break;
        end
        chk("req_ack", 32'((port ? n_a1 : n_a0) - base), 32'd1);
        if (port) p1_req = 1'b0; else p0_req = 1'b0;
    endtask

    task automatic do_both(input logic [23:0] a0, input logic [23:0] a1);
        int b0, b1;
        @(posedge clk); #1;
        p0_addr = a0; p1_addr = a1;
        p0_req = 1'b1; p1_req = 1'b1;
        b0 = n_a0; b1 = n_a1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk); #1;
            if (n_a0 != b0) p0_req = 1'b0;
            if (n_a1 != b1) p1_req = 1'b0;
            if (!p0_req && !p1_req) break;
        end
        p0_req = 1'b0; p1_req = 1'b0;
        chk("both_ack0", 32'(n_a0 - b0), 32'd1);
        chk("both_ack1", 32'(n_a1 - b1), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int rc, base, ba;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_acks",  32'({p0_ack, p1_ack, fr_rd, c_wr}), 32'd0);
        chk("rst_addr",  32'(c_addr | fr_addr), 32'd0);
        chk("rst_rdata", p0_rdata | p1_rdata, 32'd0);
        chk("rst_cnt",   32'({hit_cnt, miss_cnt}), 32'd0);
        rst_n = 1'b1;

        // Cold miss
        base = n_frrd;
        do_req(1'b0, 24'h000104, rc);
        chk("t1_frrd_n",   32'(n_frrd - base), 32'd1);
        chk("t1_fr_addr",  32'(frrd_addr), 32'h000100);
        chk("t1_wr_cyc",   32'(wr_cyc - done_cyc), 32'd1);
        chk("t1_ack_cyc",  32'(a0_cyc - done_cyc), 32'd3);
        chk("t1_rdata",    p0_rdata, 32'h5A000104);
        chk("t1_miss",     32'(miss_cnt), 32'd1);
        chk("t1_hit",      32'(hit_cnt), 32'd0);

        // Hits on the filled line, both ports
        base = n_frrd;
        do_req(1'b0, 24'h00010C, rc);
        chk("t2_frrd_n",   32'(n_frrd - base), 32'd0);
        chk("t2_lat",      32'(a0_cyc - rc), 32'd2);
        chk("t2_rdata",    p0_rdata, 32'h5A00010C);
        chk("t2_hit",      32'(hit_cnt), 32'd1);
        do_req(1'b1, 24'h000108, rc);
        chk("t2_p1_lat",   32'(a1_cyc - rc), 32'd2);
        chk("t2_p1_rdata", p1_rdata, 32'h5A000108);
        chk("t2_p0_hold",  p0_rdata, 32'h5A00010C);
        chk("t2_hit2",     32'(hit_cnt), 32'd2);

        // Tie after a p1 grant: p0 first, both miss
        base = n_frrd;
        do_both(24'h000200, 24'h000300);
        chk("t3_order_p0", 32'(a0_cyc < a1_cyc), 32'd1);
        chk("t3_rdata0",   p0_rdata, 32'h5A000200);
        chk("t3_rdata1",   p1_rdata, 32'h5A000300);
        chk("t3_frrd_n",   32'(n_frrd - base), 32'd2);
        chk("t3_cnt",      32'({hit_cnt, miss_cnt}), {16'd2, 16'd3});

        // p0 granted alone, then a cached tie goes to p1 first
        do_req(1'b0, 24'h000204, rc);
        chk("t3_p0_rdata", p0_rdata, 32'h5A000204);
        do_both(24'h00020C, 24'h000304);
        chk("t3_order_p1", 32'(a1_cyc < a0_cyc), 32'd1);
        chk("t3_b2b_gap",  32'(a0_cyc - a1_cyc), 32'd3);
        chk("t3b_rdata0",  p0_rdata, 32'h5A00020C);
        chk("t3b_rdata1",  p1_rdata, 32'h5A000304);
        chk("t3b_cnt",     32'({hit_cnt, miss_cnt}), {16'd5, 16'd3});

        // Index conflict evicts
        do_req(1'b0, 24'h000010, rc);
        do_req(1'b1, 24'h001010, rc);
        chk("t5_rdata1",   p1_rdata, 32'h5A001010);
        do_req(1'b0, 24'h000010, rc);
        chk("t5_rdata0",   p0_rdata, 32'h5A000010);
        chk("t5_cnt",      32'({hit_cnt, miss_cnt}), {16'd5, 16'd6});

        // Request dropped mid-transaction still completes exactly once
        ba = n_a0;
        @(posedge clk); #1;
        p0_addr = 24'h000400; p0_req = 1'b1;
        repeat (2) @(posedge clk);
        #1 p0_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (n_a0 != ba) break;
        end
        repeat (5) @(posedge clk);
        #1;
        chk("drop_ack_n",  32'(n_a0 - ba), 32'd1);
        chk("drop_rdata",  p0_rdata, 32'h5A000400);
        chk("drop_idle",   32'(busy), 32'd0);
        chk("drop_miss",   32'(miss_cnt), 32'd7);

        // Fixed priority: p0 held keeps winning; counters saturate at 3
        @(posedge clk); #1;
        f_p0_addr = 24'h000020; f_p1_addr = 24'h000040;
        f_p0_req = 1'b1; f_p1_req = 1'b1;
        base = nf0; ba = nf1;
        repeat (30) @(posedge clk);
        #1;
        chk("t4_p0_acks",  32'(nf0 - base), 32'd10);
        chk("t4_p1_acks",  32'(nf1 - ba), 32'd0);
        chk("t4_hit_sat",  32'(f_hit_cnt), 32'd3);
        chk("t4_p0_rdata", f_p0_rdata, 32'hC0000020);
        f_p0_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (nf1 != ba) break;
        end
        f_p1_req = 1'b0;
        chk("t4_p1_late",  32'(nf1 - ba), 32'd1);
        chk("t4_p1_rdata", f_p1_rdata, 32'hC0000040);

        // Reset while waiting on the flash reader
        ba = n_a0; base = n_frrd;
        @(posedge clk); #1;
        p0_addr = 24'h000500; p0_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (n_frrd != base) break;
        end
        chk("t6_frrd",     32'(n_frrd - base), 32'd1);
        @(posedge clk); #1;
        chk("t6_in_wait",  32'(busy), 32'd1);
        rst_n = 1'b0; p0_req = 1'b0;
        #1;
        chk("t6_busy",     32'(busy), 32'd0);
        chk("t6_strobes",  32'({fr_rd, c_wr, p0_ack, p1_ack}), 32'd0);
        chk("t6_cnt",      32'({hit_cnt, miss_cnt}), 32'd0);
        chk("t6_rdata",    p0_rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t6_no_ack",   32'(n_a0 - ba), 32'd0);
        chk("t6_no_rd",    32'(n_frrd - base), 32'd1);
        base = n_frrd;
        do_req(1'b0, 24'h000104, rc);
        chk("t6_cold_rd",  32'(n_frrd - base), 32'd1);
        chk("t6_cold_ack", 32'(a0_cyc - done_cyc), 32'd3);
        chk("t6_cold_dat", p0_rdata, 32'h5A000104);
        chk("t6_cold_cnt", 32'({hit_cnt, miss_cnt}), {16'd0, 16'd1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
